// File: rtl/usb_upload_pkg.sv
// ---------------------------------------------------------------------------
// usb_upload_pkg
// Shared constants for the EP3 upload framer.
//   SYNC0 / SYNC1 : frame sync bytes
//   HDR_LEN       : header bytes ahead of the payload (sync x2, seq, len x2)
//   ST_*          : 3-bit FSM state encodings (one per emitted-byte role)
// Optional feature macro used by the framer: USB_UPLOAD_FRAMER_CHECKSUM_EN
// ---------------------------------------------------------------------------
package usb_upload_pkg;

  localparam logic [7:0] SYNC0   = 8'hAA;
  localparam logic [7:0] SYNC1   = 8'h55;
  localparam int         HDR_LEN = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HDR0    = 3'd1;
  localparam state_t ST_HDR1    = 3'd2;
  localparam state_t ST_SEQ     = 3'd3;
  localparam state_t ST_LENH    = 3'd4;
  localparam state_t ST_LENL    = 3'd5;
  localparam state_t ST_PAYLOAD = 3'd6;
  localparam state_t ST_CSUM    = 3'd7;

endpackage

// File: rtl/usb_upload_sfifo.sv
// ---------------------------------------------------------------------------
// usb_upload_sfifo
// Single-clock first-word-fall-through byte FIFO, depth 2**AW.
// Ports:
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_wr_en, i_wr_data    : write strobe / byte (ignored while full)
//   i_rd_en               : pop strobe (ignored while empty)
//   o_rd_data             : head byte, valid whenever !o_empty
//   o_count               : occupancy 0..2**AW
//   o_full, o_empty       : occupancy flags
// ---------------------------------------------------------------------------
module usb_upload_sfifo #(
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [7:0]    r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full    = r_count[AW];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  // Storage carries no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/usb_dc_upload_framer.sv
// ---------------------------------------------------------------------------
// usb_dc_upload_framer
// Buffers a raw sample byte stream and emits framed packets to the EP3
// bulk-IN upload byte interface:
//   AA 55 SEQ LENH LENL payload[LEN] (CSUM)
// A frame opens when PAYLOAD_LEN bytes are buffered, or when a partial
// buffer has been idle for TIMEOUT cycles.
// Optional: define USB_UPLOAD_FRAMER_CHECKSUM_EN to append a two's-complement
// checksum over SEQ, LENH, LENL and the payload.
// Handshake: a sample byte transfers on a cycle with i_smp_valid && o_smp_ready;
// o_up_valid marks one upload byte per cycle and falls, one registered cycle
// late, while i_up_afull is high.
// Ports:
//   i_clk, i_reset             : 60 MHz clock, async active-high reset
//   i_enable                   : allows new frames to open (checked in IDLE)
//   i_smp_data/valid, o_smp_ready : input byte stream
//   o_up_data/valid, i_up_afull   : upload byte stream and back-pressure
//   o_drop_cnt                 : saturating count of bytes lost to a full buffer
//   o_busy                     : a frame is in progress
// ---------------------------------------------------------------------------
module usb_dc_upload_framer
  import usb_upload_pkg::*;
#(
  parameter int PAYLOAD_LEN = 256,
  parameter int BUF_AW      = 9,
  parameter int TIMEOUT     = 60000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [7:0]  i_smp_data,
  input  logic        i_smp_valid,
  output logic        o_smp_ready,
  output logic [7:0]  o_up_data,
  output logic        o_up_valid,
  input  logic        i_up_afull,
  output logic [15:0] o_drop_cnt,
  output logic        o_busy
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [7:0]    r_seq;
  logic [15:0]   r_len;
  logic [15:0]   r_rem;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_up_data;
  logic          r_up_valid;
  logic [15:0]   r_drop_cnt;

  logic [7:0]    w_rd_data;
  logic [BUF_AW:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_count32;
  logic          w_accept;
  logic          w_start;
  logic          w_emit;
  logic          w_pop;
  logic [15:0]   w_len_next;
  logic [7:0]    w_byte;

`ifdef USB_UPLOAD_FRAMER_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  usb_upload_sfifo #(.AW(BUF_AW)) u_buf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (w_accept),
    .i_wr_data (i_smp_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_count32   = 32'(w_count);
  assign o_smp_ready = !w_full;
  assign w_accept    = i_smp_valid && !w_full;
  assign w_start     = (r_state == ST_IDLE) && i_enable &&
                       ((w_count32 >= PAYLOAD_LEN) ||
                        (!w_empty && (r_timer == TMAX)));
  assign w_len_next  = (w_count32 >= PAYLOAD_LEN) ? 16'(PAYLOAD_LEN)
                                                  : w_count32[15:0];
  assign w_emit      = (r_state != ST_IDLE) && !i_up_afull;
  assign w_pop       = w_emit && (r_state == ST_PAYLOAD);

  assign o_up_data   = r_up_data;
  assign o_up_valid  = r_up_valid;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_busy      = (r_state != ST_IDLE);

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      ST_HDR0:    w_byte = SYNC0;
      ST_HDR1:    w_byte = SYNC1;
      ST_SEQ:     w_byte = r_seq;
      ST_LENH:    w_byte = r_len[15:8];
      ST_LENL:    w_byte = r_len[7:0];
      ST_PAYLOAD: w_byte = w_rd_data;
`ifdef USB_UPLOAD_FRAMER_CHECKSUM_EN
      ST_CSUM:    w_byte = 8'h00 - r_csum;
`else
      ST_CSUM:    w_byte = 8'h00;
`endif
      default:    w_byte = 8'h00;
    endcase
  end

  // Drop counter saturates so a long overflow never wraps to a small value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_drop_cnt <= '0;
    end else if (i_smp_valid && w_full && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Idle timer: restarts on every accepted byte so only a quiet input flushes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if (w_accept || w_start) begin
      r_timer <= '0;
    end else if ((r_state == ST_IDLE) && !w_empty && (r_timer != TMAX)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_up_valid <= 1'b0;
      r_up_data  <= 8'h00;
    end else begin
      r_up_valid <= w_emit;
      if (w_emit) r_up_data <= w_byte;
    end
  end

`ifdef USB_UPLOAD_FRAMER_CHECKSUM_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_csum <= 8'h00;
    end else if (w_emit) begin
      if (r_state == ST_HDR0) r_csum <= 8'h00;
      else if ((r_state == ST_SEQ) || (r_state == ST_LENH) ||
               (r_state == ST_LENL) || (r_state == ST_PAYLOAD))
        r_csum <= r_csum + w_byte;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_seq   <= 8'h00;
      r_len   <= 16'h0000;
      r_rem   <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_state <= ST_HDR0;
          r_len   <= w_len_next;
          r_rem   <= w_len_next;
        end
        ST_HDR0: if (w_emit) r_state <= ST_HDR1;
        ST_HDR1: if (w_emit) r_state <= ST_SEQ;
        ST_SEQ:  if (w_emit) r_state <= ST_LENH;
        ST_LENH: if (w_emit) r_state <= ST_LENL;
        ST_LENL: if (w_emit) r_state <= ST_PAYLOAD;
        // Only the latched length is popped; later arrivals wait for the next frame.
        ST_PAYLOAD: if (w_emit) begin
          r_rem <= r_rem - 16'd1;
          if (r_rem == 16'd1) begin
`ifdef USB_UPLOAD_FRAMER_CHECKSUM_EN
            r_state <= ST_CSUM;
`else
            r_state <= ST_IDLE;
            r_seq   <= r_seq + 8'd1;
`endif
          end
        end
        ST_CSUM: if (w_emit) begin
          r_state <= ST_IDLE;
          r_seq   <= r_seq + 8'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
